// File: rtl/debounce_multi_if.sv
// debounce_multi_if: raw button inputs and conditioned per-channel outputs of debounce_multi.
interface debounce_multi_if #(parameter int NCH = 4);
   logic [NCH-1:0] btn_raw_i;
   logic [NCH-1:0] db_level_o;
   logic [NCH-1:0] rise_o;
   logic [NCH-1:0] fall_o;
   logic [NCH-1:0] long_tick_o;
   logic           any_rise_o;
   modport master (output btn_raw_i, input db_level_o, rise_o, fall_o, long_tick_o, any_rise_o);
   modport slave  (input btn_raw_i, output db_level_o, rise_o, fall_o, long_tick_o, any_rise_o);
endinterface

// File: rtl/debounce_multi.sv
// debounce_multi: per-channel synchroniser, stability filter, edge pulses and one-shot long-press tick.
module debounce_multi #(
   parameter int             NCH        = 4,
   parameter int             CNT_W      = 21,
   parameter int             STABLE_CNT = 2000000,
   parameter int             HOLD_W     = 26,
   parameter int             HOLD_CNT   = 50000000,
   parameter logic [NCH-1:0] INV_MASK   = '0
) (
   input logic             clk,
   input logic             reset,
   debounce_multi_if.slave io
);
   if (STABLE_CNT < 1 || 64'(STABLE_CNT) >= (64'd1 << CNT_W)) begin : g_bad_stable
      $error("debounce_multi: STABLE_CNT out of range for CNT_W");
   end
   if (HOLD_CNT < 1 || 64'(HOLD_CNT) >= (64'd1 << HOLD_W)) begin : g_bad_hold
      $error("debounce_multi: HOLD_CNT out of range for HOLD_W");
   end
   localparam logic [CNT_W-1:0]  STB_M1   = CNT_W'(STABLE_CNT - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CNT);
   localparam logic [HOLD_W-1:0] HOLD_M1  = HOLD_W'(HOLD_CNT - 1);
   logic [NCH-1:0]             sync1_q, sync2_q, level_q, level_d;
   logic [NCH-1:0]             rise_q, rise_d, fall_q, fall_d, long_q, long_d;
   logic                       any_q;
   logic [NCH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic [NCH-1:0][HOLD_W-1:0] hold_q, hold_d;
   always_comb begin
      cnt_d   = '0;
      hold_d  = '0;
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      long_d  = '0;
      for (int i = 0; i < NCH; i++) begin
         // any return to the current level clears the count, so glitches never accumulate
         cnt_d[i]   = (sync2_q[i] == level_q[i] || cnt_q[i] == STB_M1) ? '0 : cnt_q[i] + 1'b1;
         level_d[i] = (sync2_q[i] != level_q[i] && cnt_q[i] == STB_M1) ? sync2_q[i] : level_q[i];
         rise_d[i]  = level_d[i] & ~level_q[i];
         fall_d[i]  = ~level_d[i] & level_q[i];
         hold_d[i]  = !level_q[i] ? '0 : (hold_q[i] < HOLD_MAX) ? hold_q[i] + 1'b1 : hold_q[i];
         long_d[i]  = level_q[i] && hold_q[i] == HOLD_M1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         long_q  <= '0;
         any_q   <= 1'b0;
      end else begin
         sync1_q <= io.btn_raw_i ^ INV_MASK;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         long_q  <= long_d;
         any_q   <= |rise_d;
      end
   end
   assign io.db_level_o  = level_q;
   assign io.rise_o      = rise_q;
   assign io.fall_o      = fall_q;
   assign io.long_tick_o = long_q;
   assign io.any_rise_o  = any_q;
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed scenarios for debounce_multi with NCH=2, STABLE_CNT=8, HOLD_CNT=20, ch1 active-low.
module tb_debounce_multi;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  debounce_multi_if #(.NCH(2)) io ();
  debounce_multi #(
    .NCH(2), .CNT_W(4), .STABLE_CNT(8), .HOLD_W(5), .HOLD_CNT(20), .INV_MASK(2'b10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(io.slave)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    io.btn_raw_i = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if ({io.db_level_o, io.rise_o, io.fall_o, io.long_tick_o, io.any_rise_o} !== 9'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got lvl=%b r=%b f=%b l=%b a=%b want all 0", i,
                 io.db_level_o, io.rise_o, io.fall_o, io.long_tick_o, io.any_rise_o);
      end
    end
    reset = 1'b0;
    tick(9);
    checks++;
    if (io.db_level_o !== 2'b00 || io.rise_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_early got lvl=%b rise=%b want 00 00", io.db_level_o, io.rise_o);
    end
    tick(1);
    checks++;
    if (io.db_level_o !== 2'b01 || io.rise_o !== 2'b01 || io.any_rise_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rise got lvl=%b rise=%b any=%b want 01 01 1",
               io.db_level_o, io.rise_o, io.any_rise_o);
    end
    io.btn_raw_i = 2'b10;
    tick(10);
    checks++;
    if (io.db_level_o !== 2'b00 || io.fall_o !== 2'b01) begin
      errors++;
      $display("FAIL reset_release_fall got lvl=%b fall=%b want 00 01", io.db_level_o, io.fall_o);
    end
    tick(2);
  endtask
  task automatic test_press();
    io.btn_raw_i = 2'b11;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      checks++;
      if (io.db_level_o !== 2'b00 || io.rise_o !== 2'b00) begin
        errors++;
        $display("FAIL press_wait cyc=%0d got lvl=%b rise=%b want 00 00", i, io.db_level_o, io.rise_o);
      end
    end
    tick(1);
    checks++;
    if (io.db_level_o !== 2'b01 || io.rise_o !== 2'b01 || io.fall_o !== 2'b00 ||
        io.long_tick_o !== 2'b00 || io.any_rise_o !== 1'b1) begin
      errors++;
      $display("FAIL press_edge got lvl=%b r=%b f=%b l=%b a=%b want 01 01 00 00 1",
               io.db_level_o, io.rise_o, io.fall_o, io.long_tick_o, io.any_rise_o);
    end
    tick(1);
    checks++;
    if (io.db_level_o !== 2'b01 || io.rise_o !== 2'b00 || io.any_rise_o !== 1'b0) begin
      errors++;
      $display("FAIL press_after got lvl=%b rise=%b any=%b want 01 00 0",
               io.db_level_o, io.rise_o, io.any_rise_o);
    end
    io.btn_raw_i = 2'b10;
    tick(10);
    checks++;
    if (io.db_level_o !== 2'b00 || io.fall_o !== 2'b01 || io.long_tick_o !== 2'b00) begin
      errors++;
      $display("FAIL press_release got lvl=%b fall=%b long=%b want 00 01 00",
               io.db_level_o, io.fall_o, io.long_tick_o);
    end
    tick(2);
  endtask
  task automatic test_glitch();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        io.btn_raw_i = (i < 5) ? 2'b11 : 2'b10;
        tick(1);
        checks++;
        if ({io.db_level_o, io.rise_o, io.fall_o, io.long_tick_o, io.any_rise_o} !== 9'd0) begin
          errors++;
          $display("FAIL glitch r=%0d i=%0d got lvl=%b r=%b f=%b l=%b want all 0", r, i,
                   io.db_level_o, io.rise_o, io.fall_o, io.long_tick_o);
        end
      end
    end
    tick(10);
    checks++;
    if (io.db_level_o !== 2'b00 || io.fall_o !== 2'b00) begin
      errors++;
      $display("FAIL glitch_settle got lvl=%b fall=%b want 00 00", io.db_level_o, io.fall_o);
    end
  endtask
  task automatic test_long_press();
    io.btn_raw_i = 2'b11;
    tick(10);
    checks++;
    if (io.rise_o !== 2'b01) begin
      errors++;
      $display("FAIL long_rise got rise=%b want 01", io.rise_o);
    end
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      checks++;
      if (io.long_tick_o !== ((k == 20) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL long_tick k=%0d got %b want %b", k, io.long_tick_o, (k == 20) ? 2'b01 : 2'b00);
      end
    end
    io.btn_raw_i = 2'b10;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      checks++;
      if (io.fall_o !== 2'b00 || io.long_tick_o !== 2'b00 || io.db_level_o !== 2'b01) begin
        errors++;
        $display("FAIL long_release_wait cyc=%0d got f=%b l=%b lvl=%b want 00 00 01", i,
                 io.fall_o, io.long_tick_o, io.db_level_o);
      end
    end
    tick(1);
    checks++;
    if (io.fall_o !== 2'b01 || io.long_tick_o !== 2'b00 || io.db_level_o !== 2'b00) begin
      errors++;
      $display("FAIL long_release got f=%b l=%b lvl=%b want 01 00 00",
               io.fall_o, io.long_tick_o, io.db_level_o);
    end
    tick(2);
  endtask
  task automatic test_multi_channel();
    io.btn_raw_i = 2'b11;
    tick(12);
    io.btn_raw_i = 2'b00;
    tick(9);
    checks++;
    if (io.db_level_o !== 2'b01) begin
      errors++;
      $display("FAIL cross_wait got lvl=%b want 01", io.db_level_o);
    end
    tick(1);
    checks++;
    if (io.db_level_o !== 2'b10 || io.rise_o !== 2'b10 || io.fall_o !== 2'b01 || io.any_rise_o !== 1'b1) begin
      errors++;
      $display("FAIL cross_edge got lvl=%b r=%b f=%b a=%b want 10 10 01 1",
               io.db_level_o, io.rise_o, io.fall_o, io.any_rise_o);
    end
    io.btn_raw_i = 2'b10;
    tick(10);
    checks++;
    if (io.db_level_o !== 2'b00 || io.fall_o !== 2'b10) begin
      errors++;
      $display("FAIL ch1_release got lvl=%b fall=%b want 00 10", io.db_level_o, io.fall_o);
    end
    tick(2);
    io.btn_raw_i = 2'b01;
    tick(10);
    checks++;
    if (io.db_level_o !== 2'b11 || io.rise_o !== 2'b11 || io.any_rise_o !== 1'b1) begin
      errors++;
      $display("FAIL both_press got lvl=%b rise=%b any=%b want 11 11 1",
               io.db_level_o, io.rise_o, io.any_rise_o);
    end
    io.btn_raw_i = 2'b10;
    tick(10);
    checks++;
    if (io.db_level_o !== 2'b00 || io.fall_o !== 2'b11 || io.rise_o !== 2'b00) begin
      errors++;
      $display("FAIL both_release got lvl=%b fall=%b rise=%b want 00 11 00",
               io.db_level_o, io.fall_o, io.rise_o);
    end
    tick(2);
  endtask
  task automatic test_mid_reset();
    io.btn_raw_i = 2'b11;
    tick(7);
    reset = 1'b1;
    tick(2);
    checks++;
    if ({io.db_level_o, io.rise_o, io.fall_o, io.long_tick_o, io.any_rise_o} !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset got lvl=%b r=%b f=%b l=%b a=%b want all 0",
               io.db_level_o, io.rise_o, io.fall_o, io.long_tick_o, io.any_rise_o);
    end
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      checks++;
      if (io.db_level_o !== 2'b00 || io.rise_o !== 2'b00 || io.fall_o !== 2'b00) begin
        errors++;
        $display("FAIL mid_reset_restart cyc=%0d got lvl=%b r=%b f=%b want 00 00 00", i,
                 io.db_level_o, io.rise_o, io.fall_o);
      end
    end
    tick(1);
    checks++;
    if (io.db_level_o !== 2'b01 || io.rise_o !== 2'b01) begin
      errors++;
      $display("FAIL mid_reset_rise got lvl=%b rise=%b want 01 01", io.db_level_o, io.rise_o);
    end
  endtask
  initial begin
    io.btn_raw_i = 2'b10;
    test_reset();
    test_press();
    test_glitch();
    test_long_press();
    test_multi_channel();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
